// File: rtl/ddr3_pkg.sv
// Shared DDR3 user-port definitions: command codes, default widths and the
// command arbiter's FSM state encoding.
package ddr3_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 64;

  localparam logic [3:0] CMD_NADA       = 4'b0000;
  localparam logic [3:0] CMD_READ       = 4'b0001;
  localparam logic [3:0] CMD_WRITE      = 4'b0010;
  localparam logic [3:0] CMD_PDOWN_ENT  = 4'b0011;
  localparam logic [3:0] CMD_PDOWN_EXIT = 4'b0100;
  localparam logic [3:0] CMD_SREF_ENT   = 4'b0101;
  localparam logic [3:0] CMD_SREF_EXIT  = 4'b0110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CMD   = 3'd2,
    ST_WDATA = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/ddr3_rd_tag_fifo.sv
// In-order FIFO of 1-bit requester tags for outstanding reads. A push is
// accepted when full only if a pop happens in the same cycle.
module ddr3_rd_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter for two requesters in front of the DDR3 user command
// port; read data is routed back through an in-order tag FIFO.
module ddr3_cmd_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_wr,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [DATA_W-1:0]   req_wdata0,
  input  logic [DATA_W-1:0]   req_wdata1,
  output logic [1:0]          req_ack,
  output logic [1:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                init_done,
  output logic                err,
  input  logic                cmd_rdy,
  input  logic                datain_rdy,
  input  logic                read_data_valid,
  input  logic                wl_err,
  input  logic [DATA_W-1:0]   read_data,
  output logic                cmd_valid,
  output logic [3:0]          cmd,
  output logic [4:0]          cmd_burst_cnt,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [DATA_W/8-1:0] data_mask,
  output state_t              fsm_state
);

  // Handshakes: a requester holds req_valid (with req_wr/addr/wdata) until it
  // sees a one-cycle req_ack; the core gets a one-cycle cmd_valid strobe with
  // cmd/addr, and write_data stays stable until datain_rdy is sampled high.

  state_t state_q, state_d;
  logic [1:0] elig;
  logic       winner;
  logic       grant;
  logic       last_grant;
  logic       cur_wr;
  logic       tag_full;
  logic       tag_empty;
  logic       tag_dout;
  logic       tag_push;
  logic       tag_pop;

  assign cmd_burst_cnt = 5'b00001;
  assign data_mask     = '0;
  assign fsm_state     = state_q;

  always_comb begin
    elig     = req_valid & (req_wr | {2{~tag_full}});
    winner   = (&elig) ? ~last_grant : elig[1];
    grant    = (state_q == ST_IDLE) && cmd_rdy && (|elig);
    tag_push = grant && !req_wr[winner];
    tag_pop  = read_data_valid && !tag_empty;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (cmd_rdy) state_d = ST_IDLE;
      ST_IDLE:  if (grant) state_d = ST_CMD;
      ST_CMD:   state_d = cur_wr ? ST_WDATA : ST_GAP;
      ST_WDATA: if (datain_rdy) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ack    <= 2'b00;
      last_grant <= 1'b1;
      cur_wr     <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      cmd_valid  <= 1'b0;
      cmd        <= CMD_NADA;
      rd_valid   <= 2'b00;
      rd_data    <= '0;
      init_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      req_ack <= grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
      if (grant) begin
        last_grant <= winner;
        cur_wr     <= req_wr[winner];
        addr       <= winner ? req_addr1 : req_addr0;
        if (req_wr[winner])
          write_data <= winner ? req_wdata1 : req_wdata0;
      end
      cmd_valid <= (state_q == ST_CMD);
      cmd       <= (state_q == ST_CMD) ? (cur_wr ? CMD_WRITE : CMD_READ) : CMD_NADA;
      rd_valid  <= tag_pop ? (tag_dout ? 2'b10 : 2'b01) : 2'b00;
      if (tag_pop)
        rd_data <= read_data;
      if (state_q == ST_INIT && cmd_rdy)
        init_done <= 1'b1;
      if (wl_err || (read_data_valid && tag_empty))
        err <= 1'b1;
    end
  end

  ddr3_rd_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tag_push),
    .din  (winner),
    .pop  (tag_pop),
    .full (tag_full),
    .empty(tag_empty),
    .dout (tag_dout)
  );

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed bench for ddr3_cmd_arbiter: a cycle-by-cycle vector table plus
// hand-written reset-mid-write and wl_err sequences.
module tb_ddr3_cmd_arbiter;
  import ddr3_pkg::*;

  localparam int AW = 26;
  localparam int DW = 64;
  localparam logic [AW-1:0] A0 = 26'h0001400;
  localparam logic [AW-1:0] A1 = 26'h1555555;
  localparam logic [DW-1:0] W0 = 64'hCAFE_F00D_0000_0001;
  localparam logic [DW-1:0] W1 = 64'h0BAD_0000_0000_0002;
  localparam logic [DW-1:0] DD = 64'hDEADBEEFAAAA5555;
  localparam logic [DW-1:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [DW-1:0] RA = 64'hA5A5_A5A5_0000_1111;
  localparam logic [DW-1:0] RB = 64'h5A5A_5A5A_0000_2222;
  localparam logic [DW-1:0] RC = 64'h1234_0000_5678_3333;
  localparam logic [DW-1:0] RD = 64'hFFFF_0000_FFFF_4444;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_wr;
  logic [AW-1:0]   req_addr0, req_addr1;
  logic [DW-1:0]   req_wdata0, req_wdata1;
  logic [1:0]      req_ack, rd_valid;
  logic [DW-1:0]   rd_data;
  logic            init_done, err;
  logic            cmd_rdy, datain_rdy, read_data_valid, wl_err;
  logic [DW-1:0]   read_data;
  logic            cmd_valid;
  logic [3:0]      cmd;
  logic [4:0]      cmd_burst_cnt;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   write_data;
  logic [DW/8-1:0] data_mask;
  state_t          fsm_state;

  int checks = 0;
  int errors = 0;

  ddr3_cmd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .init_done(init_done), .err(err), .cmd_rdy(cmd_rdy),
    .datain_rdy(datain_rdy), .read_data_valid(read_data_valid),
    .wl_err(wl_err), .read_data(read_data), .cmd_valid(cmd_valid),
    .cmd(cmd), .cmd_burst_cnt(cmd_burst_cnt), .addr(addr),
    .write_data(write_data), .data_mask(data_mask), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    rv;
    logic [1:0]    rw;
    logic          crdy;
    logic          drdy;
    logic          rdv;
    logic [DW-1:0] rdat;
    logic [1:0]    ack;
    logic          cv;
    logic [3:0]    cmd;
    logic [1:0]    rdvx;
    logic [DW-1:0] rdatx;
    state_t        st;
    logic [AW-1:0] addr;
    logic          err;
  } vec_t;

  localparam int NV = 30;
  vec_t vt[NV];

  function automatic vec_t v(logic [1:0] rv, logic [1:0] rw, logic crdy,
                             logic drdy, logic rdv, logic [DW-1:0] rdat,
                             logic [1:0] ack, logic cv, logic [3:0] c,
                             logic [1:0] rdvx, logic [DW-1:0] rdatx,
                             state_t st, logic [AW-1:0] a, logic e);
    vec_t r;
    r.rv = rv; r.rw = rw; r.crdy = crdy; r.drdy = drdy; r.rdv = rdv;
    r.rdat = rdat; r.ack = ack; r.cv = cv; r.cmd = c; r.rdvx = rdvx;
    r.rdatx = rdatx; r.st = st; r.addr = a; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_wr = 2'b00; cmd_rdy = 1'b0; datain_rdy = 1'b0;
    read_data_valid = 1'b0; wl_err = 1'b0; read_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    req_addr0 = A0; req_addr1 = A1; req_wdata0 = W0; req_wdata1 = W1;

    //      rv     rw    cr dr rv rdat | ack  cv cmd        rdv   rdat  state     addr err
    vt[0]  = v(2'b01, 2'b01, 0, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_INIT,  '0, 0);
    vt[1]  = v(2'b01, 2'b01, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  '0, 0);
    vt[2]  = v(2'b01, 2'b01, 1, 0, 0, '0, 2'b01, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A0, 0);
    vt[3]  = v(2'b00, 2'b00, 0, 0, 0, '0, 2'b00, 1, CMD_WRITE, 2'b00, '0, ST_WDATA, A0, 0);
    vt[4]  = v(2'b00, 2'b00, 0, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_WDATA, A0, 0);
    vt[5]  = v(2'b00, 2'b00, 0, 1, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_GAP,   A0, 0);
    vt[6]  = v(2'b00, 2'b00, 0, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A0, 0);
    vt[7]  = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b10, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A1, 0);
    vt[8]  = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 1, CMD_READ,  2'b00, '0, ST_GAP,   A1, 0);
    vt[9]  = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A1, 0);
    vt[10] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b01, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A0, 0);
    vt[11] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 1, CMD_READ,  2'b00, '0, ST_GAP,   A0, 0);
    vt[12] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A0, 0);
    vt[13] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b10, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A1, 0);
    vt[14] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 1, CMD_READ,  2'b00, '0, ST_GAP,   A1, 0);
    vt[15] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A1, 0);
    vt[16] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b01, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A0, 0);
    vt[17] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 1, CMD_READ,  2'b00, '0, ST_GAP,   A0, 0);
    vt[18] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A0, 0);
    // four reads outstanding: reads blocked, a write still goes through
    vt[19] = v(2'b11, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A0, 0);
    vt[20] = v(2'b11, 2'b01, 1, 0, 0, '0, 2'b01, 0, CMD_NADA,  2'b00, '0, ST_CMD,   A0, 0);
    vt[21] = v(2'b10, 2'b00, 1, 0, 0, '0, 2'b00, 1, CMD_WRITE, 2'b00, '0, ST_WDATA, A0, 0);
    vt[22] = v(2'b10, 2'b00, 1, 1, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_GAP,   A0, 0);
    vt[23] = v(2'b10, 2'b00, 1, 0, 0, '0, 2'b00, 0, CMD_NADA,  2'b00, '0, ST_IDLE,  A0, 0);
    vt[24] = v(2'b10, 2'b00, 1, 0, 1, DD, 2'b00, 0, CMD_NADA,  2'b10, DD, ST_IDLE,  A0, 0);
    vt[25] = v(2'b10, 2'b00, 1, 0, 1, D1, 2'b10, 0, CMD_NADA,  2'b01, D1, ST_CMD,   A1, 0);
    vt[26] = v(2'b00, 2'b00, 1, 0, 1, RA, 2'b00, 1, CMD_READ,  2'b10, RA, ST_GAP,   A1, 0);
    vt[27] = v(2'b00, 2'b00, 1, 0, 1, RB, 2'b00, 0, CMD_NADA,  2'b01, RB, ST_IDLE,  A1, 0);
    vt[28] = v(2'b00, 2'b00, 1, 0, 1, RC, 2'b00, 0, CMD_NADA,  2'b10, RC, ST_IDLE,  A1, 0);
    vt[29] = v(2'b00, 2'b00, 1, 0, 1, RD, 2'b00, 0, CMD_NADA,  2'b00, RC, ST_IDLE,  A1, 1);

    do_reset();
    chk("rst state", 64'(fsm_state), 64'(ST_INIT));
    chk("rst cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst req_ack", 64'(req_ack), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst init_done", 64'(init_done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst cmd", 64'(cmd), 64'(CMD_NADA));
    chk("rst addr", 64'(addr), 64'd0);
    chk("rst write_data", write_data, 64'd0);
    chk("rst rd_data", rd_data, 64'd0);
    chk("burst_cnt", 64'(cmd_burst_cnt), 64'd1);
    chk("data_mask", 64'(data_mask), 64'd0);

    for (int i = 0; i < NV; i++) begin
      req_valid = vt[i].rv; req_wr = vt[i].rw; cmd_rdy = vt[i].crdy;
      datain_rdy = vt[i].drdy; read_data_valid = vt[i].rdv;
      read_data = vt[i].rdat;
      tick();
      chk($sformatf("v%0d req_ack", i), 64'(req_ack), 64'(vt[i].ack));
      chk($sformatf("v%0d cmd_valid", i), 64'(cmd_valid), 64'(vt[i].cv));
      chk($sformatf("v%0d cmd", i), 64'(cmd), 64'(vt[i].cmd));
      chk($sformatf("v%0d rd_valid", i), 64'(rd_valid), 64'(vt[i].rdvx));
      chk($sformatf("v%0d rd_data", i), rd_data, vt[i].rdatx);
      chk($sformatf("v%0d state", i), 64'(fsm_state), 64'(vt[i].st));
      chk($sformatf("v%0d addr", i), 64'(addr), 64'(vt[i].addr));
      chk($sformatf("v%0d err", i), 64'(err), 64'(vt[i].err));
      chk($sformatf("v%0d init_done", i), 64'(init_done), (i >= 1) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d write_data", i), write_data, (i >= 2) ? W0 : 64'd0);
    end

    // Reset asserted while waiting for datain_rdy, then restart.
    do_reset();
    req_valid = 2'b10; req_wr = 2'b10; cmd_rdy = 1'b1;
    tick();
    tick();
    chk("mid ack", 64'(req_ack), 64'b10);
    req_valid = 2'b00; cmd_rdy = 1'b0;
    tick();
    chk("mid wdata state", 64'(fsm_state), 64'(ST_WDATA));
    chk("mid cmd_valid", 64'(cmd_valid), 64'd1);
    chk("mid write_data", write_data, W1);
    #2 rst = 1'b1;
    #1;
    chk("async cmd_valid", 64'(cmd_valid), 64'd0);
    chk("async state", 64'(fsm_state), 64'(ST_INIT));
    chk("async init_done", 64'(init_done), 64'd0);
    chk("async cmd", 64'(cmd), 64'(CMD_NADA));
    chk("async write_data", write_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11; req_wr = 2'b00; cmd_rdy = 1'b1;
    tick();
    chk("restart state", 64'(fsm_state), 64'(ST_IDLE));
    chk("restart req_ack", 64'(req_ack), 64'd0);
    tick();
    chk("restart tie ack", 64'(req_ack), 64'b01);
    chk("restart addr", 64'(addr), 64'(A0));
    req_valid = 2'b00; cmd_rdy = 1'b0;
    tick();
    chk("restart cmd", 64'(cmd), 64'(CMD_READ));
    chk("pre wl_err err", 64'(err), 64'd0);

    wl_err = 1'b1;
    tick();
    wl_err = 1'b0;
    chk("wl_err err", 64'(err), 64'd1);
    tick();
    chk("wl_err sticky", 64'(err), 64'd1);
    chk("wl_err rd_valid", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_arbiter.md
# ddr3_cmd_arbiter

Two-requester arbiter in front of the DDR3 core's user command port. It arbitrates READ/WRITE requests round-robin, sequences the core's cmd_rdy / cmd_valid / datain_rdy handshake, and routes read_data back to the requester that issued each read using an in-order tag FIFO. It sits between the DDR3 core and client blocks such as test sequencers and DMA engines, which no longer drive the core directly.

## Interface
- ADDR_W, 26, DDR3 user address width
- DATA_W, 64, user data width
- TAG_DEPTH, 4, outstanding reads allowed (power of two)
---
- clk  in  1  core user clock
- rst  in  1  reset; asynchronous, active-high. Reset rst, asynchronous, active-high; clock clk.
- req_valid  in  2  per-requester request pending (level, held until ack)
- req_wr  in  2  per requester: 1 = WRITE, 0 = READ
- req_addr0 / req_addr1  in  ADDR_W  request address
- req_wdata0 / req_wdata1  in  DATA_W  write data
- req_ack  out  2  one-cycle pulse: request accepted; requester may change inputs next cycle
- rd_valid  out  2  one-cycle pulse: rd_data belongs to this requester
- rd_data  out  DATA_W  registered copy of core read_data
- init_done  out  1  sticky; set on the first cmd_rdy
- err  out  1  sticky; set on wl_err, or on read_data_valid with the tag FIFO empty
- cmd_rdy, datain_rdy, read_data_valid, wl_err  in  1  core status
- read_data  in  DATA_W  core read data
- cmd_valid  out  1  one-cycle command strobe to core
- cmd  out  4  core command code
- cmd_burst_cnt  out  5  constant 5'b00001
- addr  out  ADDR_W  command address
- write_data  out  DATA_W  write data to core
- data_mask  out  DATA_W/8  constant 0

## Operation
- States: INIT, IDLE, CMD, WDATA, GAP.
- INIT: wait for cmd_rdy, then set init_done and go to IDLE. No grants are issued in INIT, even if cmd_rdy and req_valid rise together.
- Eligibility: a requester is eligible when req_valid=1 and it is not a READ while the tag FIFO is full.
- IDLE, when cmd_rdy=1 and at least one requester is eligible:
  - Pick the winner: if both are eligible, grant the one not granted last; if one is eligible, grant it.
  - Pulse req_ack[winner].
  - Latch cmd (READ/WRITE), addr, and write_data (writes only).
  - Update last-grant to the winner.
  - On a READ, push the winner's index into the tag FIFO.
  - Go to CMD.
- CMD: cmd_valid=1 for exactly this cycle. Next state is WDATA on a write, GAP on a read.
- WDATA: hold write_data stable until datain_rdy=1, then go to GAP.
- GAP: one dead cycle so cmd_rdy can deassert, then go to IDLE. cmd_rdy is ignored in CMD, WDATA and GAP.
- Read return (independent of the FSM): on read_data_valid with the FIFO non-empty, pop the tag, register read_data to rd_data, and pulse rd_valid[tag] on the next cycle.
- Simultaneous push and pop are legal at any occupancy, including full and empty.
- read_data_valid with the FIFO empty sets err and produces no rd_valid.
- When not in CMD, cmd = NADA (4'b0000). addr and write_data hold their last values.

## Timing
- Reset values:
  - state = INIT, last-grant = 1 (requester 0 wins the first tie), FIFO empty.
  - cmd_valid, req_ack, rd_valid, init_done, err = 0.
  - cmd = NADA; addr, write_data, rd_data = 0.
- Grant latency: req_ack is registered and asserts the cycle after the IDLE condition is true. cmd_valid follows one cycle after req_ack.
- Issue rate: minimum 3 cycles per read (IDLE→CMD→GAP). Writes take 3 cycles plus the datain_rdy wait.
- Read return latency: rd_valid and rd_data appear 1 cycle after read_data_valid.
- Reset mid-operation: all of the above return to reset values immediately. In-flight reads are forgotten, so late read_data_valid sets err after reset; this is accepted.
- req_valid deasserting before its ack is a requester protocol violation. The behaviour is undefined (no check is performed).

## Structure
- Shared package ddr3_pkg: command encodings (NADA, READ=4'b0001, WRITE=4'b0010, PDOWN_ENT/EXIT, etc.), ADDR_W/DATA_W defaults, and the FSM state encoding.
- Sub-module ddr3_rd_tag_fifo: 1-bit wide, TAG_DEPTH deep, with push, pop, full, empty and dout. It is synchronous with asynchronous reset.

## Test plan
- Init: drive req_valid=2'b01 before the first cmd_rdy → no req_ack until 1 cycle after cmd_rdy. Then expect cmd=WRITE, cmd_valid for 1 cycle, and write_data held until datain_rdy.
- Round-robin: both requesters post READs continuously with cmd_rdy held high → grants alternate 0,1,0,1. addr alternates req_addr0/req_addr1 (e.g. 26'h0001400 / 26'h1555555).
- Read routing: issue READ by 1 then READ by 0; return 64'hDEADBEEFAAAA5555 then 64'h0123456789ABCDEF → rd_valid=2'b10 then 2'b01, each with the matching rd_data.
- Tag full: 4 outstanding reads with no returns → a 5th READ gets no ack while a pending WRITE from the other requester is still granted. One read_data_valid → the READ is granted.
- Errors: read_data_valid with no reads outstanding → err=1, no rd_valid. Separately, a wl_err pulse → err=1.
- Reset mid-WDATA: assert rst while waiting for datain_rdy → cmd_valid=0, state INIT, init_done=0. After release, the next cmd_rdy restarts operation.
